// File: rtl/keypad_pkg.sv
// Shared key codes, FSM state encoding and key/state classification helpers
// for the keypad code lock.
package keypad_pkg;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;
  localparam logic [3:0] KEY_PROG  = 4'hC;

  typedef enum logic [2:0] {
    ENTRY_0  = 3'd0,
    ENTRY_1  = 3'd1,
    ENTRY_2  = 3'd2,
    UNLOCKED = 3'd3,
    PROG_0   = 3'd4,
    PROG_1   = 3'd5,
    PROG_2   = 3'd6,
    LOCKOUT  = 3'd7
  } lock_state_t;

  function automatic logic is_digit(input logic [3:0] key);
    return (key <= 4'd9);
  endfunction

  // Open states are the ones where the lock reports unlocked.
  function automatic logic is_open(input lock_state_t st);
    return (st == UNLOCKED) || (st == PROG_0) || (st == PROG_1) || (st == PROG_2);
  endfunction

endpackage

// File: rtl/keypad_code_lock_if.sv
// Keypad code-lock bus: decoder ready/key towards the lock, display digits and
// status flags back from it.
interface keypad_code_lock_if;
  logic       ready;
  logic [3:0] key;
  logic [3:0] d1;
  logic [3:0] d0;
  logic       unlocked;
  logic       locked_out;
  logic       err;

  modport master (output ready, key, input d1, d0, unlocked, locked_out, err);
  modport slave  (input ready, key, output d1, d0, unlocked, locked_out, err);
endinterface

// File: rtl/key_strobe_sync.sv
// Brings the asynchronous keypad ready into the clk domain and turns each
// rising edge into a single-cycle strobe (two sync flops plus edge detect).
module key_strobe_sync (
  input  logic clk,
  input  logic reset,
  input  logic ready,
  output logic strobe
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Synchronizer chain and previous-value flop for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      prev_r <= 1'b0;
    end else begin
      meta_r <= ready;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign strobe = sync_r & ~prev_r;

endmodule

// File: rtl/keypad_code_lock.sv
// Two-digit keypad code lock: digit entry, code compare, code programming and
// failure lockout. Define AUTO_RELOCK_EN to relock after an idle period.
module keypad_code_lock
  import keypad_pkg::*;
#(
  parameter logic [7:0] DEFAULT_CODE   = 8'h42,
  parameter int         LOCK_TRIES     = 3,
  parameter int         LOCKOUT_CYCLES = 1000,
  parameter int         RELOCK_CYCLES  = 5000
) (
  input logic               clk,
  input logic               reset,
  keypad_code_lock_if.slave bus
);

  localparam int LOCK_W = $clog2(LOCKOUT_CYCLES);
  localparam int FAIL_W = $clog2(LOCK_TRIES + 1);
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES - 1);
  localparam logic [LOCK_W-1:0] LOCK_ZERO = {LOCK_W{1'b0}};
  localparam logic [LOCK_W-1:0] LOCK_ONE  = LOCK_W'(1);
  localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(LOCK_TRIES);
  localparam logic [FAIL_W-1:0] FAIL_ZERO = {FAIL_W{1'b0}};
  localparam logic [FAIL_W-1:0] FAIL_ONE  = FAIL_W'(1);

  if (LOCK_TRIES < 1 || LOCKOUT_CYCLES < 2 || RELOCK_CYCLES < 1) begin : g_param_check
    $error("keypad_code_lock: parameter out of range");
  end

  lock_state_t       state_r, state_next_s;
  logic [3:0]        d1_r, d0_r, d1_next_s, d0_next_s;
  logic [7:0]        code_r, code_next_s;
  logic [FAIL_W-1:0] fail_cnt_r, fail_next_s, fail_inc_s;
  logic [LOCK_W-1:0] lock_cnt_r, lock_next_s;
  logic              err_s, err_r, unlocked_r, locked_out_r;
  logic              strobe_s, digit_s, clear_s, enter_s, prog_s, in_prog_s;
  logic              relock_s;

  key_strobe_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .ready  (bus.ready),
    .strobe (strobe_s)
  );

  assign digit_s   = is_digit(bus.key);
  assign clear_s   = (bus.key == KEY_CLEAR);
  assign enter_s   = (bus.key == KEY_ENTER);
  assign prog_s    = (bus.key == KEY_PROG);
  assign in_prog_s = (state_r == PROG_0) || (state_r == PROG_1) || (state_r == PROG_2);
  assign fail_inc_s = (fail_cnt_r == FAIL_MAX) ? FAIL_MAX : (fail_cnt_r + FAIL_ONE);

`ifdef AUTO_RELOCK_EN
  localparam int IDLE_W = $clog2(RELOCK_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(RELOCK_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_ZERO = {IDLE_W{1'b0}};
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
  logic [IDLE_W-1:0] idle_cnt_r;

  assign relock_s = is_open(state_r) && !strobe_s && (idle_cnt_r == IDLE_LAST);

  // Idle timer: open-state cycles since the last key strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt_r <= IDLE_ZERO;
    end else if (!is_open(state_r) || strobe_s || relock_s) begin
      idle_cnt_r <= IDLE_ZERO;
    end else begin
      idle_cnt_r <= idle_cnt_r + IDLE_ONE;
    end
  end
`else
  assign relock_s = 1'b0;
`endif

  // Next-state, datapath and err decode for the current strobe or timer event.
  always_comb begin
    state_next_s = state_r;
    d1_next_s    = d1_r;
    d0_next_s    = d0_r;
    code_next_s  = code_r;
    fail_next_s  = fail_cnt_r;
    lock_next_s  = lock_cnt_r;
    err_s        = 1'b0;
    case (state_r)
      ENTRY_0, PROG_0, ENTRY_1, PROG_1: begin
        if (!strobe_s) begin
          state_next_s = state_r;
        end else if (digit_s) begin
          if (state_r == ENTRY_0 || state_r == PROG_0) begin
            d1_next_s    = bus.key;
            state_next_s = in_prog_s ? PROG_1 : ENTRY_1;
          end else begin
            d0_next_s    = bus.key;
            state_next_s = in_prog_s ? PROG_2 : ENTRY_2;
          end
        end else if (clear_s) begin
          d1_next_s    = 4'd0;
          d0_next_s    = 4'd0;
          state_next_s = in_prog_s ? UNLOCKED : ENTRY_0;
        end else if (enter_s || prog_s) begin
          err_s = 1'b1;
        end else begin
          state_next_s = state_r;
        end
      end
      ENTRY_2, PROG_2: begin
        if (!strobe_s) begin
          state_next_s = state_r;
        end else if (digit_s || prog_s) begin
          err_s = 1'b1;
        end else if (clear_s) begin
          d1_next_s    = 4'd0;
          d0_next_s    = 4'd0;
          state_next_s = in_prog_s ? UNLOCKED : ENTRY_0;
        end else if (enter_s) begin
          d1_next_s = 4'd0;
          d0_next_s = 4'd0;
          if (in_prog_s) begin
            code_next_s  = {d1_r, d0_r};
            state_next_s = UNLOCKED;
          end else if ({d1_r, d0_r} == code_r) begin
            fail_next_s  = FAIL_ZERO;
            state_next_s = UNLOCKED;
          end else begin
            err_s       = 1'b1;
            fail_next_s = fail_inc_s;
            if (fail_inc_s == FAIL_MAX) begin
              lock_next_s  = LOCK_LOAD;
              state_next_s = LOCKOUT;
            end else begin
              state_next_s = ENTRY_0;
            end
          end
        end else begin
          state_next_s = state_r;
        end
      end
      UNLOCKED: begin
        if (!strobe_s) begin
          state_next_s = state_r;
        end else if (enter_s || clear_s) begin
          state_next_s = ENTRY_0;
        end else if (prog_s) begin
          d1_next_s    = 4'd0;
          d0_next_s    = 4'd0;
          state_next_s = PROG_0;
        end else if (digit_s) begin
          err_s = 1'b1;
        end else begin
          state_next_s = state_r;
        end
      end
      LOCKOUT: begin
        if (lock_cnt_r == LOCK_ZERO) begin
          fail_next_s  = FAIL_ZERO;
          state_next_s = ENTRY_0;
        end else begin
          lock_next_s = lock_cnt_r - LOCK_ONE;
        end
      end
      default: begin
        state_next_s = ENTRY_0;
      end
    endcase
    // Idle relock drops any half-entered programming digits.
    if (relock_s) begin
      d1_next_s    = 4'd0;
      d0_next_s    = 4'd0;
      state_next_s = ENTRY_0;
    end else begin
      state_next_s = state_next_s;
    end
  end

  // FSM state, digit/code registers and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ENTRY_0;
      d1_r       <= 4'd0;
      d0_r       <= 4'd0;
      code_r     <= DEFAULT_CODE;
      fail_cnt_r <= FAIL_ZERO;
      lock_cnt_r <= LOCK_ZERO;
    end else begin
      state_r    <= state_next_s;
      d1_r       <= d1_next_s;
      d0_r       <= d0_next_s;
      code_r     <= code_next_s;
      fail_cnt_r <= fail_next_s;
      lock_cnt_r <= lock_next_s;
    end
  end

  // Status outputs registered from the next state so they line up with the digits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      unlocked_r   <= 1'b0;
      locked_out_r <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      unlocked_r   <= is_open(state_next_s);
      locked_out_r <= (state_next_s == LOCKOUT);
      err_r        <= err_s;
    end
  end

  assign bus.d1         = d1_r;
  assign bus.d0         = d0_r;
  assign bus.unlocked   = unlocked_r;
  assign bus.locked_out = locked_out_r;
  assign bus.err        = err_r;

endmodule
